jt51_lfo_gen: RTL and testbench
===============================

Name: jt51_lfo_gen

Overview:
Low-frequency oscillator that produces the per-sample phase-modulation word `pm` consumed upstream of the phase generator. `pm` feeds the PM/keycode extension ahead of the phase-increment lookup. The block also produces an amplitude-modulation word `am` for the envelope path. It advances once per 32-slot sample, shapes one of four waveforms, and scales each output by its depth register.

Parameters:
SEED, 17'h00001, non-zero reset value of noise LFSR

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
cen  input  1  clock enable; all state changes only on clk edges with cen=1
zero  input  1  high in slot 0 of every 32-slot sample; sample tick = cen & zero
lfrq  input  8  LFO frequency: [7:4] exponent E, [3:0] mantissa M
w  input  2  waveform: 0 saw, 1 square, 2 triangle, 3 noise
amd  input  7  AM depth 0..127
pmd  input  7  PM depth 0..127
lfo_rst  input  1  test/reset bit: holds LFO phase at zero
am  output  8  unsigned AM value
pm  output  8  two's-complement PM value, to PG pm input

Behaviour:
- Reset (rst_n=0, async):
  - phase accumulator ph[19:0]=0, LFSR=SEED, noise n=SEED[7:0].
  - Shaper registers u=0, b=0; outputs am=0, pm=0.
- Phase, on each sample tick:
  - ph <= lfo_rst ? 0 : ph + ({1'b1,M} << E), modulo 2^20 (wrap silently).
  - lfo_rst wins over the increment.
  - Phase index p = ph[19:12].
- Noise:
  - 17-bit LFSR shifts left every sample tick, including while lfo_rst=1. New bit = lfsr[16]^lfsr[13]. Never reaches all-zero.
  - n <= lfsr[7:0] on any sample tick where the ph add carries out of bit 15 (ph[19:16] changes, including the wrap to 0).
  - No noise update on ticks where lfo_rst=1.
- Shaper, on every cen, registered into u (unsigned AM) and b (signed PM):
  - saw: u = 255-p; b = p^8'h80.
  - square: u = p[7] ? 0 : 255; b = p[7] ? -128 : 127.
  - triangle, with d = {p[5:0],1'b0}:
    - u = p[7] ? {p[6:0],1'b0} : ~{p[6:0],1'b0}.
    - b by p[7:6]: 0 -> +d; 1 -> +(127-d); 2 -> -d; 3 -> -(127-d). Range -127..127.
  - noise: u = n; b = n^8'h80.
- Scale, on every cen:
  - am <= (u*amd)>>7, as unsigned 15-bit product then bits [14:7].
  - pm <= (b*pmd)>>>7, as signed 15-bit product, arithmetic shift (floor), bits [14:7].
  - amd=0 gives am=0; pmd=0 gives pm=0.
  - Extremes: am max 253; pm range -127..126.
- Latency: ph update at cen edge k; u/b at the next cen edge; am/pm at the cen edge after that (2 cen cycles). No handshake; outputs are held between updates.
- Register inputs (lfrq, w, amd, pmd) are sampled continuously:
  - lfrq change takes effect on the next sample tick.
  - w, amd and pmd changes take effect on the next cen.
- Stalls and slot handling:
  - cen=0 freezes all state.
  - zero without cen is ignored.
  - zero held for multiple cen cycles gives one tick per cen cycle.
- rst_n asserted mid-operation clears everything immediately; the first tick after release increments from ph=0.

Decomposition:
- Package jt51_lfo_pkg:
  - waveform constants W_SAW=0, W_SQR=1, W_TRI=2, W_NOISE=3;
  - LFSR width 17 and tap positions (16, 13);
  - ph width 20 and phase-index MSB/LSB (19, 12);
  - noise latch bit 15.
- One sub-module: jt51_lfo_noise. It contains the LFSR plus the n latch, with inputs tick, carry15, hold, and output n[7:0].
- Shaper and scaler stay in the top level.

Test Plan:
- Reset: hold rst_n=0, toggle clk with cen=1 -> am=0, pm=0, ph=0; release, then 2 cen with no tick -> outputs stay 0 with w=0, amd=pmd=0.
- Square, max rate: lfrq=8'hF0, w=1, amd=pmd=127 -> ph alternates 0/0x80000 each tick; am alternates 253/0 and pm 126/-127, 2 cen after each tick.
- Saw, slowest rate: lfrq=8'h00, w=0, amd=pmd=127, 4096 ticks -> ph=0x10000, p=0x10, am=237, pm=-112.
- lfo_rst mid-run: after test 3, assert lfo_rst for 1 tick -> ph=0 that tick, am=253, pm=-128*127>>>7=-127 two cen later; LFSR continues advancing.
- Noise: lfrq=8'hF0, w=3 -> n updates every tick and matches a software LFSR model (seed 1, taps 16^13) for 1000 ticks; LFSR never 0; am=(n*amd)>>7.
- Stall/depth: cen=0 for 100 clk with zero=1 -> no state change; then amd=0, pmd=0 -> am=0, pm=0 on the second cen.

Source files
------------

// File: rtl/jt51_lfo_pkg.sv
// Shared constants for the JT51 LFO: waveform codes, phase geometry and noise LFSR taps.
// Also holds the bipolar triangle shaping helper used by the top level.
package jt51_lfo_pkg;

  localparam logic [1:0] W_SAW   = 2'd0;
  localparam logic [1:0] W_SQR   = 2'd1;
  localparam logic [1:0] W_TRI   = 2'd2;
  localparam logic [1:0] W_NOISE = 2'd3;

  localparam int unsigned LfsrW    = 17;
  localparam int unsigned LfsrTapA = 16;
  localparam int unsigned LfsrTapB = 13;

  localparam int unsigned PhW      = 20;
  localparam int unsigned PhIdxMsb = 19;
  localparam int unsigned PhIdxLsb = 12;
  localparam int unsigned NoiseBit = 15;

  // Quarter-wave folded triangle, symmetric around zero (-127..127).
  function automatic logic [7:0] tri_bipolar(input logic [7:0] p);
    logic [6:0] d;
    logic [7:0] r;
    d = {p[5:0], 1'b0};
    unique case (p[7:6])
      2'd0:    r = {1'b0, d};
      2'd1:    r = {1'b0, 7'd127 - d};
      2'd2:    r = -{1'b0, d};
      default: r = -{1'b0, 7'd127 - d};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt51_lfo_gen_if.sv
// Register/output bundle of the LFO: control fields from the register file and the
// per-sample AM/PM words delivered to the envelope and phase generators.
interface jt51_lfo_gen_if;
  logic       cen;
  logic       zero;
  logic [7:0] lfrq;
  logic [1:0] w;
  logic [6:0] amd;
  logic [6:0] pmd;
  logic       lfo_rst;
  logic [7:0] am;
  logic [7:0] pm;

  modport master (
    output cen, zero, lfrq, w, amd, pmd, lfo_rst,
    input  am, pm
  );

  modport slave (
    input  cen, zero, lfrq, w, amd, pmd, lfo_rst,
    output am, pm
  );
endinterface

// File: rtl/jt51_lfo_noise.sv
// Noise source for the LFO: free-running 17-bit LFSR stepped every sample tick, with an
// 8-bit sample latched whenever the phase crosses a 2^16 boundary.
module jt51_lfo_noise
  import jt51_lfo_pkg::*;
#(
  parameter logic [LfsrW-1:0] SEED = 17'h00001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       carry15,
  input  logic       hold,
  output logic [7:0] n
);

  logic [LfsrW-1:0] lfsr_q;

  // Shift-left with xor feedback is invertible, so a non-zero seed never reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      n      <= SEED[7:0];
    end else if (tick) begin
      lfsr_q <= {lfsr_q[LfsrW-2:0], lfsr_q[LfsrTapA] ^ lfsr_q[LfsrTapB]};
      if (carry15 && !hold) begin
        n <= lfsr_q[7:0];
      end
    end
  end

endmodule

// File: rtl/jt51_lfo_gen.sv
// JT51 LFO: phase accumulator, four-waveform shaper and depth scaling producing the
// unsigned AM word and the two's-complement PM word, two enabled cycles after each tick.
module jt51_lfo_gen
  import jt51_lfo_pkg::*;
#(
  parameter logic [LfsrW-1:0] SEED = 17'h00001
) (
  input  logic           clk,
  input  logic           rst_n,
  jt51_lfo_gen_if.slave  bus
);

  logic           tick;
  logic [PhW-1:0] ph_q;
  logic [PhW-1:0] ph_inc;
  logic [PhW-1:0] ph_sum;
  logic           carry15;
  logic [7:0]     noise;
  logic [7:0]     p;
  logic [7:0]     u_d, u_q;
  logic [7:0]     b_d, b_q;
  logic [14:0]    am_prod;
  logic signed [15:0] pm_prod;
  logic [7:0]     am_d, am_q;
  logic [7:0]     pm_d, pm_q;

  assign tick = bus.cen & bus.zero;

  always_comb begin
    ph_inc  = {{(PhW-5){1'b0}}, 1'b1, bus.lfrq[3:0]} << bus.lfrq[7:4];
    ph_sum  = ph_q + ph_inc;
    // Any change of the top nibble, wrap included, counts as a noise-latch event.
    carry15 = ph_sum[PhW-1:NoiseBit+1] != ph_q[PhW-1:NoiseBit+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
    end else if (tick) begin
      ph_q <= bus.lfo_rst ? '0 : ph_sum;
    end
  end

  jt51_lfo_noise #(
    .SEED (SEED)
  ) u_noise (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .carry15 (carry15),
    .hold    (bus.lfo_rst),
    .n       (noise)
  );

  always_comb begin
    p   = ph_q[PhIdxMsb:PhIdxLsb];
    u_d = 8'd0;
    b_d = 8'd0;
    unique case (bus.w)
      W_SAW: begin
        u_d = ~p;
        b_d = p ^ 8'h80;
      end
      W_SQR: begin
        u_d = p[7] ? 8'd0 : 8'd255;
        b_d = p[7] ? 8'h80 : 8'h7f;
      end
      W_TRI: begin
        u_d = p[7] ? {p[6:0], 1'b0} : ~{p[6:0], 1'b0};
        b_d = tri_bipolar(p);
      end
      default: begin
        u_d = noise;
        b_d = noise ^ 8'h80;
      end
    endcase
  end

  always_comb begin
    am_prod = {7'd0, u_q} * {8'd0, bus.amd};
    pm_prod = $signed({{8{b_q[7]}}, b_q}) * $signed({9'd0, bus.pmd});
    am_d    = 8'(am_prod >> 7);
    pm_d    = 8'(pm_prod >>> 7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q  <= 8'd0;
      b_q  <= 8'd0;
      am_q <= 8'd0;
      pm_q <= 8'd0;
    end else if (bus.cen) begin
      u_q  <= u_d;
      b_q  <= b_d;
      am_q <= am_d;
      pm_q <= pm_d;
    end
  end

  assign bus.am = am_q;
  assign bus.pm = pm_q;

endmodule

// File: tb/tb_jt51_lfo_gen.sv
// Scoreboard bench for jt51_lfo_gen: stimulus queues expected AM/PM/phase against a
// target enabled-cycle count; an independent monitor compares when that count arrives.
module tb_jt51_lfo_gen;

  logic clk;
  logic rst_n;

  jt51_lfo_gen_if bus ();

  jt51_lfo_gen #(
    .SEED (17'h00001)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned tgt;
    bit          chk_out;
    logic [7:0]  am;
    logic [7:0]  pm;
    logic [19:0] ph;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cen_cnt = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [16:0] lfsr_m;
  logic [7:0]  n_m;
  logic [19:0] ph_m;

  always @(posedge clk) begin
    if (rst_n && bus.cen) cen_cnt <= cen_cnt + 1;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cen %0d)", nm, act, exp, cen_cnt);
    end
  endfunction

  // Monitor: pop every entry whose target enabled-cycle has been reached.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].tgt < cen_cnt) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: missed, now cen %0d, expected at cen %0d", sb[i].name, cen_cnt,
                 sb[i].tgt);
        sb.delete(i);
      end else if (sb[i].tgt == cen_cnt) begin
        if (sb[i].chk_out) begin
          check({sb[i].name, ".am"}, {24'd0, bus.am}, {24'd0, sb[i].am});
          check({sb[i].name, ".pm"}, {24'd0, bus.pm}, {24'd0, sb[i].pm});
        end else begin
          check({sb[i].name, ".ph"}, {12'd0, dut.ph_q}, {12'd0, sb[i].ph});
        end
        sb.delete(i);
      end
    end
  end

  function automatic void expect_out(input int unsigned off, input logic [7:0] am,
                                     input logic [7:0] pm, input string nm);
    exp_t e;
    e.tgt = cen_cnt + off; e.chk_out = 1'b1; e.am = am; e.pm = pm; e.ph = '0; e.name = nm;
    sb.push_back(e);
  endfunction

  function automatic void expect_ph(input int unsigned off, input logic [19:0] ph,
                                    input string nm);
    exp_t e;
    e.tgt = cen_cnt + off; e.chk_out = 1'b0; e.am = '0; e.pm = '0; e.ph = ph; e.name = nm;
    sb.push_back(e);
  endfunction

  function automatic logic [7:0] am_f(input logic [7:0] u, input logic [6:0] d);
    int unsigned r;
    r = (int'(u) * int'(d)) >> 7;
    return r[7:0];
  endfunction

  function automatic logic [7:0] pm_f(input logic [7:0] b, input logic [6:0] d);
    int          prod;
    logic [31:0] r;
    prod = int'($signed(b)) * int'(d);
    r    = prod >>> 7;
    return r[7:0];
  endfunction

  task automatic step(input logic z);
    bus.cen  = 1'b1;
    bus.zero = z;
    @(posedge clk);
    #1;
    bus.zero = 1'b0;
  endtask

  // Sample tick with the behavioural phase/noise model advanced alongside.
  task automatic tick_step();
    logic [19:0] inc;
    logic [19:0] nxt;
    inc = {15'd0, 1'b1, bus.lfrq[3:0]} << bus.lfrq[7:4];
    nxt = ph_m + inc;
    if (!bus.lfo_rst && nxt[19:16] != ph_m[19:16]) n_m = lfsr_m[7:0];
    lfsr_m = {lfsr_m[15:0], lfsr_m[16] ^ lfsr_m[13]};
    ph_m   = bus.lfo_rst ? 20'd0 : nxt;
    step(1'b1);
  endtask

  task automatic model_reset();
    lfsr_m = 17'h00001;
    n_m    = 8'h01;
    ph_m   = 20'd0;
  endtask

  initial begin
    bus.cen = 1'b1; bus.zero = 1'b0; bus.lfrq = 8'h00; bus.w = 2'd0;
    bus.amd = 7'd0; bus.pmd = 7'd0; bus.lfo_rst = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset holds everything at zero even with cen toggling the clock.
    repeat (3) @(posedge clk);
    #1;
    expect_out(0, 8'd0, 8'd0, "rst");
    expect_ph(0, 20'd0, "rst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    expect_out(2, 8'd0, 8'd0, "idle");
    step(1'b0);
    step(1'b0);

    // Square at max rate: phase toggles 0 / 0x80000 every tick.
    bus.lfrq = 8'hF0; bus.w = 2'd1; bus.amd = 7'd127; bus.pmd = 7'd127;
    for (int i = 0; i < 8; i++) begin
      tick_step();
      expect_ph(0, ((i % 2) == 0) ? 20'h80000 : 20'h00000, "sqr");
      if ((i % 2) == 0) expect_out(2, 8'd0, 8'h81, "sqr_hi");
      else              expect_out(2, 8'd253, 8'd126, "sqr_lo");
    end
    step(1'b0);
    step(1'b0);

    // Saw at the slowest rate: 4096 ticks of 16 reach 0x10000.
    bus.lfrq = 8'h00; bus.w = 2'd0;
    repeat (4096) tick_step();
    expect_ph(0, 20'h10000, "saw");
    expect_out(2, 8'd237, 8'h90, "saw");
    step(1'b0);
    step(1'b0);

    // lfo_rst forces phase to zero on the tick.
    bus.lfo_rst = 1'b1;
    tick_step();
    bus.lfo_rst = 1'b0;
    expect_ph(0, 20'd0, "lforst");
    expect_out(2, 8'd253, 8'h81, "lforst");
    step(1'b0);
    step(1'b0);

    // Noise: n refreshes every tick at max rate.
    bus.lfrq = 8'hF0; bus.w = 2'd3;
    for (int i = 0; i < 1000; i++) begin
      tick_step();
      expect_out(2, am_f(n_m, 7'd127), pm_f(n_m ^ 8'h80, 7'd127), "noise");
    end
    step(1'b0);
    step(1'b0);
    check("lfsr", {15'd0, dut.u_noise.lfsr_q}, {15'd0, lfsr_m});

    // Stall: zero without cen must not move anything.
    bus.cen = 1'b0; bus.zero = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    expect_out(0, am_f(n_m, 7'd127), pm_f(n_m ^ 8'h80, 7'd127), "stall");
    expect_ph(0, ph_m, "stall");
    bus.zero = 1'b0;
    @(negedge clk);
    #1;
    bus.amd = 7'd0; bus.pmd = 7'd0;
    expect_out(1, 8'd0, 8'd0, "depth0_a");
    expect_out(2, 8'd0, 8'd0, "depth0_b");
    step(1'b0);
    step(1'b0);

    // Asynchronous reset mid-cycle, then first tick increments from zero.
    bus.lfrq = 8'h10; bus.w = 2'd0; bus.amd = 7'd127; bus.pmd = 7'd127;
    step(1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    expect_out(0, 8'd0, 8'd0, "mrst");
    expect_ph(0, 20'd0, "mrst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick_step();
    expect_ph(0, 20'h00020, "mrst_tick");
    expect_out(2, 8'd253, 8'h81, "mrst_tick");
    step(1'b0);
    step(1'b0);
    step(1'b0);

    while (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never compared, expected at cen %0d", sb[0].name, sb[0].tgt);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
